// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU (IDLE/EXEC/RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to req0.
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_src1,
   input  logic [DATA_W-1:0] req0_src2,
   input  logic [2:0]        req0_ctr,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_src1,
   input  logic [DATA_W-1:0] req1_src2,
   input  logic [2:0]        req1_ctr,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   output logic [2:0]        alu_ctr,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic [DATA_W-1:0] src1_q, src1_d;
   logic [DATA_W-1:0] src2_q, src2_d;
   logic [2:0]        ctr_q, ctr_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              zero_q, zero_d;
   logic              win;
   logic              any_v;

   assign any_v = req0_valid | req1_valid;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // On contention the requester not granted last time wins.
   assign win = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
`else
   assign win = ~req0_valid;
`endif

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      ctr_d      = ctr_q;
      res_d      = res_q;
      zero_d     = zero_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_d     = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (rst_n && any_v) begin
               req0_ready = ~win;
               req1_ready = win;
               gnt_d      = win;
               src1_d     = win ? req1_src1 : req0_src1;
               src2_d     = win ? req1_src2 : req0_src2;
               ctr_d      = win ? req1_ctr : req0_ctr;
               state_d    = EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
               last_d     = win;
`endif
            end
         end
         EXEC: begin
            res_d   = alu_result;
            zero_d  = alu_zero;
            state_d = RESP;
         end
         RESP: begin
            if (gnt_q ? rsp1_ready : rsp0_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         src1_q  <= '0;
         src2_q  <= '0;
         ctr_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         ctr_q   <= ctr_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
      end
   end

`ifdef ALU_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // ALU inputs come only from the latched operands, so they never follow live requests.
   assign alu_src1    = src1_q;
   assign alu_src2    = src2_q;
   assign alu_ctr     = ctr_q;

   assign rsp0_valid  = (state_q == RESP) && !gnt_q;
   assign rsp1_valid  = (state_q == RESP) && gnt_q;
   assign rsp0_result = res_q;
   assign rsp1_result = res_q;
   assign rsp0_zero   = zero_q;
   assign rsp1_zero   = zero_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width; SHALL match the ALU datapath width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 reqN_src1, reqN_src2  input  DATA_W  operands of requester N.
REQ-007 reqN_ctr  input  3  op code: 000 and, 001 or, 010 xor, 011 nor, 100 slt, 101 add, 110 sub, 111 move.
REQ-008 rspN_valid  output  1  result for requester N available.
REQ-009 rspN_ready  input  1  requester N consumes the result.
REQ-010 rspN_result  output  DATA_W; rspN_zero  output  1  registered ALU result and zero flag.
REQ-011 alu_src1, alu_src2  output  DATA_W; alu_ctr  output  3  drive the shared combinational ALU.
REQ-012 alu_result  input  DATA_W; alu_zero  input  1  returned by the shared ALU.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP; no other state reachable.
REQ-014 IDLE: reqN_ready SHALL be high only for the arbitration winner among valid requesters, combinationally; both low if none valid.
REQ-015 Transfer on reqN_valid and reqN_ready at an edge: operands, ctr and grant ID latched; IDLE->EXEC.
REQ-016 EXEC: alu_src1/src2/ctr SHALL drive latched values; next edge captures alu_result/alu_zero into the response registers; EXEC->RESP.
REQ-017 Outside EXEC, alu_* outputs SHALL hold the last latched values (no glitching to requester inputs).
REQ-018 RESP: rspN_valid high only for the granted N; result/zero stable until rspN_ready sampled high; then RESP->IDLE.
REQ-019 Latency: accept at edge k -> rspN_valid high from edge k+1; minimum 3 cycles per operation.
REQ-020 reqN_ready SHALL be low in EXEC and RESP; requests arriving then wait, not dropped.
REQ-021 rspN_ready while rspN_valid low SHALL have no effect.
REQ-022 Both valid in IDLE: winner per REQ-026; loser keeps valid, served in a later IDLE.
REQ-023 Operand widths SHALL pass unmodified; no sign extension or truncation by the arbiter.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, all ready/valid outputs low, result/zero/latched operands/alu_* to 0, last-grant to 1, regardless of state (including mid-EXEC or mid-RESP; in-flight op discarded).
REQ-025 Reset release SHALL take effect at the first rising edge with rst_n high; no spurious response after release.

Configuration
REQ-026 Macro ALU_ARB_ROUND_ROBIN_EN: defined -> on contention the requester not granted last wins (last-grant resets to 1, so requester 0 wins first tie); undefined -> fixed priority, requester 0 always wins contention and last-grant register SHALL be absent.

Verification
REQ-027 Single req0 add: src1=5, src2=7, ctr=101 -> rsp0_valid one cycle after accept, rsp0_result=12, rsp0_zero=0, rsp1_valid never high.
REQ-028 req1 sub: src1=9, src2=9, ctr=110 with rsp1_ready held low 4 cycles -> rsp1_result=0, rsp1_zero=1 held stable; req0 stays unaccepted until RESP exits.
REQ-029 Both valid continuously, 4 ops each: with ALU_ARB_ROUND_ROBIN_EN grants 0,1,0,1,...; without it all 4 req0 ops first, then req1.
REQ-030 rst_n pulsed low during EXEC of req0 and 0x0000FFFF -> all outputs 0 asynchronously, no rsp0_valid after release, next req0 served normally.
REQ-031 Back-to-back req0 ops with rsp0_ready tied high: slt 3<8 -> 1, then move 0xDEADBEEF -> 0xDEADBEEF; exactly 3 cycles between accepts.
